dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer for the shared byte-addressed, big-endian data memory of the multi-cycle CPU.
- Port 0 is the CPU memory stage. Port 1 is the debug/program loader.
- Grants one word access at a time with round-robin fairness.
- Drives the memory's active-low read/write strobes. The memory acts on the falling edge of CLK.
- Rejects misaligned or out-of-range addresses without touching memory.

Parameters:
- DEPTH, 256, memory size in bytes; must be a multiple of 4.
- AW, 32, address width of requester and memory ports.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 direction: 1 = write, 0 = read.
- addr0  in  AW  port 0 byte address.
- wdata0  in  32  port 0 write data.
- ack0  out  1  port 0 completion pulse, one cycle.
- err0  out  1  port 0 error flag, valid with ack0.
- rdata0  out  32  port 0 read data, valid with ack0.
- req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1.
- mem_rd_n  out  1  memory read strobe; 0 = read.
- mem_wr_n  out  1  memory write strobe; 0 = write.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; Z when mem_rd_n = 1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST = 0, asynchronous): state = IDLE, last = 1 (port 0 wins the first tie).
  - All outputs are 0, except mem_rd_n = 1 and mem_wr_n = 1.
- All outputs are registered.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the port that is not `last`.
  - On grant, latch sel, we, addr and wdata of the granted port, and set last = sel.
  - Address check at grant time: addr[1:0] != 0 or addr > DEPTH-4 goes to ERR. Otherwise go to ACCESS.
  - At the ACCESS entry edge, drive mem_addr and mem_wdata. Assert mem_wr_n = 0 if we = 1, else mem_rd_n = 0.
- ACCESS (exactly 1 cycle):
  - The memory samples the strobes at the mid-cycle falling edge.
  - At the exiting rising edge:
    - Deassert both strobes to 1.
    - If read, capture mem_rdata into rdata<sel>.
    - Go to RESP and assert ack<sel> = 1.
- RESP (1 cycle): ack<sel> = 1 and err<sel> = 0. On exit, clear ack and go to IDLE unconditionally.
- ERR (1 cycle):
  - ack<sel> = 1 and err<sel> = 1. rdata<sel> is held at its previous value.
  - No strobe is asserted. Return to IDLE.
- Requester handshake:
  - The requester samples ack on the rising edge ending RESP/ERR and drops or changes req on that same edge.
  - IDLE therefore lasts at least 1 cycle, so there is no spurious re-grant.
- Latency: grant edge to ack = 2 cycles for a valid access, 1 cycle for an error. Sustained throughput is 1 access per 3 cycles.
- rdata<n> holds its value until the next read completes on that port. A write does not alter rdata.
- Request inputs are ignored outside IDLE. A req arriving mid-access waits; it is not lost if held.
- A req dropped before grant is a legal cancellation; no ack is issued.
- Only one of ack0/ack1 is ever high. mem_rd_n and mem_wr_n are never both 0.
- Reset mid-ACCESS forces the strobes high asynchronously. The memory write may or may not complete, which is acceptable.
- Address is compared as an unsigned AW-bit value. An upper-bit-set address is out of range.

Test Plan:
- Reset, then port 0 write addr0 = 0x10, wdata0 = 0xDEADBEEF, then read 0x10.
  - Required: mem_wr_n low exactly 1 cycle with mem_addr = 0x10.
  - Required: the read gives ack0 2 cycles after the grant, rdata0 = 0xDEADBEEF, err0 = 0.
- Port 1 write 0x11223344 at 0x00, port 0 read at 0x00.
  - Required: rdata0 = 0x11223344 (big-endian bytes 0x11, 0x22, 0x33, 0x44 at 0..3).
- req0 and req1 held continuously for 6 accesses after reset.
  - Required: grants alternate 0, 1, 0, 1, 0, 1 with one ack every 3 cycles, never both acks high.
- Port 0 read at 0x13 and at 0xFD (DEPTH = 256).
  - Required: ack0 and err0 high 1 cycle after grant, mem_rd_n and mem_wr_n stay 1, rdata0 unchanged.
- Port 0 read at 0xFC.
  - Required: valid access, err0 = 0.
- Assert RST low during ACCESS of a write.
  - Required: mem_wr_n = 1 and busy = 0 immediately, no ack.
  - Required: after release, the next req0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// shared byte-addressed, big-endian data memory.
// Ports:
//   CLK, RST                   clock, async active-low reset
//   req/we/addr/wdata{0,1}     requester inputs (0 = CPU mem stage, 1 = loader)
//   ack/err/rdata{0,1}         requester responses, valid while ack is high
//   mem_rd_n, mem_wr_n         active-low memory strobes (memory acts on negedge)
//   mem_addr, mem_wdata        memory address / write data
//   mem_rdata                  memory read data
//   busy                       high whenever the sequencer is not IDLE
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [31:0]   rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [31:0]   rdata1,
  output logic          mem_rd_n,
  output logic          mem_wr_n,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int unsigned DW = 32;
  // Highest legal word-aligned byte address.
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            we_q, we_d;

  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;

  logic            grant_c;
  logic            gsel_c;
  logic            g_we_c;
  logic [AW-1:0]   g_addr_c;
  logic [DW-1:0]   g_wdata_c;
  logic            addr_bad_c;

  // State register plus registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Arbitration and next-state logic; on a tie the port that did not win last goes.
  always_comb begin
    gsel_c     = (req0 && req1) ? ~last_q : req1;
    g_we_c     = gsel_c ? we1 : we0;
    g_addr_c   = gsel_c ? addr1 : addr0;
    g_wdata_c  = gsel_c ? wdata1 : wdata0;
    grant_c    = (state_q == IDLE) && (req0 || req1);
    addr_bad_c = (g_addr_c[1:0] != 2'b00) || (g_addr_c > LAST_WORD);
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          sel_d   = gsel_c;
          we_d    = g_we_c;
          last_d  = gsel_c;
          state_d = addr_bad_c ? ERR : ACCESS;
        end
      end
      ACCESS:    state_d = RESP;
      RESP, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output next-values: strobes launch on the grant edge, ack on the edge after.
  always_comb begin
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          if (addr_bad_c) begin
            // Rejected without touching memory: respond immediately with err.
            ack0_d = ~gsel_c;
            ack1_d = gsel_c;
            err0_d = ~gsel_c;
            err1_d = gsel_c;
          end else begin
            mem_addr_d  = g_addr_c;
            mem_wdata_d = g_wdata_c;
            wr_n_d      = ~g_we_c;
            rd_n_d      = g_we_c;
          end
        end
      end
      ACCESS: begin
        ack0_d = ~sel_q;
        ack1_d = sel_q;
        if (!we_q) begin
          if (sel_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_rd_n  = rd_n_q;
  assign mem_wr_n  = wr_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// big-endian byte memory model that acts on the falling clock edge.
module tb_dmem_arbiter;

  logic        CLK, RST;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_rd_n, mem_wr_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [7:0]  mem [0:255];

  dmem_arbiter #(.DEPTH(256), .AW(32)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: writes and reads happen at the falling edge; garbage otherwise.
  always @(negedge CLK) begin
    if (!mem_wr_n) begin
      mem[mem_addr[7:0]]         = mem_wdata[31:24];
      mem[mem_addr[7:0] + 8'd1]  = mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd2]  = mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd3]  = mem_wdata[7:0];
    end
    if (!mem_rd_n)
      mem_rdata <= {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                    mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};
    else
      mem_rdata <= 32'hA5A5_A5A5;
  end

  // Protocol invariants watched throughout.
  always @(negedge CLK) begin
    if (RST && ((ack0 && ack1) || (!mem_rd_n && !mem_wr_n))) viol++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request and reports what was observed; checks are done by callers.
  task automatic run_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic e,
                         output logic [31:0] rd, output int wr_cyc, output int rd_cyc,
                         output logic [31:0] wr_addr, output logic ack_after);
    lat = 0; e = 1'b0; rd = '0; wr_cyc = 0; rd_cyc = 0; wr_addr = '0; ack_after = 1'b1;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (!mem_wr_n) begin wr_cyc++; wr_addr = mem_addr; end
      if (!mem_rd_n) rd_cyc++;
      if ((p == 0) ? ack0 : ack1) begin
        lat = i;
        e   = (p == 0) ? err0 : err1;
        rd  = (p == 0) ? rdata0 : rdata1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    ack_after = (p == 0) ? ack0 : ack1;
  endtask

  int          lat, wrc, rdc;
  logic        e, aa;
  logic [31:0] rd, wa;

  task automatic test_reset();
    RST = 1'b1;
    #2 RST = 1'b0;
    tick(); tick();
    n_checks++; if (mem_rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b want 1", mem_rd_n); end
    n_checks++; if (mem_wr_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr_n: got %b want 1", mem_wr_n); end
    n_checks++; if ({ack0, err0, ack1, err1, busy} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {ack0, err0, ack1, err1, busy}); end
    n_checks++; if ({rdata0, rdata1, mem_addr, mem_wdata} !== 128'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {rdata0, rdata1, mem_addr, mem_wdata}); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    run_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (wrc !== 1) begin n_fail++; $display("FAIL wr_strobe_cycles: got %0d want 1", wrc); end
    n_checks++; if (wa !== 32'h10) begin n_fail++; $display("FAIL wr_addr: got %h want 00000010", wa); end
    n_checks++; if (rdc !== 0) begin n_fail++; $display("FAIL wr_no_rd_strobe: got %0d want 0", rdc); end
    n_checks++; if (lat !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL wr_ack: got lat=%0d err=%b want lat=2 err=0", lat, e); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 00000000", rd); end
    run_req(0, 1'b0, 32'h10, 32'h0, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d want 2", lat); end
    n_checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, e); end
    n_checks++; if (rdc !== 1 || wrc !== 0) begin n_fail++; $display("FAIL rd_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rdc, wrc); end
    n_checks++; if (aa !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b want 0", aa); end
  endtask

  task automatic test_big_endian();
    logic [31:0] bytes;
    run_req(1, 1'b1, 32'h00, 32'h1122_3344, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (lat !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL p1_wr_ack: got lat=%0d err=%b want lat=2 err=0", lat, e); end
    bytes = {mem[0], mem[1], mem[2], mem[3]};
    n_checks++; if (bytes !== 32'h1122_3344) begin n_fail++; $display("FAIL be_bytes: got %h want 11223344", bytes); end
    run_req(0, 1'b0, 32'h00, 32'h0, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL be_read: got %h want 11223344", rd); end
  endtask

  task automatic test_addr_errors();
    logic [31:0] bad [3];
    bad[0] = 32'h13; bad[1] = 32'hFD; bad[2] = 32'h1000_0010;
    for (int k = 0; k < 3; k++) begin
      run_req(0, 1'b0, bad[k], 32'h0, lat, e, rd, wrc, rdc, wa, aa);
      n_checks++; if (lat !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL err_ack[%0d]: got lat=%0d err=%b want lat=1 err=1", k, lat, e); end
      n_checks++; if (rdc !== 0 || wrc !== 0) begin n_fail++; $display("FAIL err_strobes[%0d]: got rd=%0d wr=%0d want 0 0", k, rdc, wrc); end
      n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL err_rdata_hold[%0d]: got %h want 11223344", k, rd); end
    end
  endtask

  task automatic test_top_word();
    run_req(1, 1'b1, 32'hFC, 32'hCAFE_F00D, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (lat !== 2 || e !== 1'b0 || wa !== 32'hFC) begin n_fail++; $display("FAIL top_wr: got lat=%0d err=%b addr=%h want 2 0 fc", lat, e, wa); end
    run_req(0, 1'b0, 32'hFC, 32'h0, lat, e, rd, wrc, rdc, wa, aa);
    n_checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL top_rd: got lat=%0d err=%b data=%h want 2 0 cafef00d", lat, e, rd); end
  endtask

  task automatic test_round_robin();
    int          ack_t [6];
    int          ack_p [6];
    logic [31:0] ack_d [6];
    int          n = 0;
    RST = 1'b0; tick(); RST = 1'b1; tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h00;
    for (int i = 1; i <= 30 && n < 6; i++) begin
      tick();
      if (ack0 || ack1) begin
        ack_t[n] = i;
        ack_p[n] = ack1 ? 1 : 0;
        ack_d[n] = ack1 ? rdata1 : rdata0;
        n++;
        if (n == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", n); end
    for (int k = 0; k < n; k++) begin
      n_checks++; if (ack_p[k] !== (k % 2)) begin n_fail++; $display("FAIL rr_port[%0d]: got %0d want %0d", k, ack_p[k], k % 2); end
      n_checks++; if (ack_t[k] !== 2 + 3 * k) begin n_fail++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", k, ack_t[k], 2 + 3 * k); end
      n_checks++; if (ack_d[k] !== ((k % 2) ? 32'h1122_3344 : 32'hDEAD_BEEF)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h", k, ack_d[k]); end
    end
  endtask

  task automatic test_reset_mid_access();
    int first = -1;
    int got1  = 0;
    run_req(1, 1'b0, 32'h00, 32'h0, lat, e, rd, wrc, rdc, wa, aa);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h5555_5555;
    tick();
    n_checks++; if (mem_wr_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got wr_n=%b busy=%b want 0 1", mem_wr_n, busy); end
    #2 RST = 1'b0;
    #1;
    n_checks++; if (mem_wr_n !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got wr_n=%b busy=%b ack0=%b want 1 0 0", mem_wr_n, busy, ack0); end
    req0 = 1'b0;
    tick(); tick();
    n_checks++; if (ack0 !== 1'b0 || mem_wr_n !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got ack0=%b wr_n=%b want 0 1", ack0, mem_wr_n); end
    RST = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h00;
    for (int i = 1; i <= 20 && got1 == 0; i++) begin
      tick();
      if (ack0 && first < 0) begin first = 0; req0 = 1'b0; end
      if (ack1) begin if (first < 0) first = 1; got1 = 1; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_checks++; if (first !== 0) begin n_fail++; $display("FAIL midrst_first_grant: got %0d want 0", first); end
    n_checks++; if (got1 !== 1) begin n_fail++; $display("FAIL midrst_second_grant: got %0d want 1", got1); end
  endtask

  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_big_endian();
    test_addr_errors();
    test_top_word();
    test_round_robin();
    test_reset_mid_access();
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL invariants: got %0d violations want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
